// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: owns the PC, fetches words over a req/gnt/rvalid
// handshake and presents the fetched instruction with its PC to decode.
module inst_fetch #(
  parameter int unsigned          DWIDTH   = 32,
  parameter logic [DWIDTH-1:0]    RESET_PC = '0,
  parameter logic [31:0]          NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCSel,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic              stall,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] pc_plus4,
  output logic              misaligned
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_TRAP
  } state_t;

  localparam logic [DWIDTH-1:0] PC_STEP   = DWIDTH'(4);
  localparam logic [DWIDTH-1:0] BIT0_MASK = {{(DWIDTH-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              misaligned_q, misaligned_d;
  logic [DWIDTH-1:0] target;

  assign pc_plus4 = pc_q + PC_STEP;
  // Jump targets drop bit 0 as JALR does; only bit 1 can then misalign.
  assign target   = (PCSel ? alu_out : pc_plus4) & BIT0_MASK;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    misaligned_d = misaligned_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        imem_req_d = 1'b1;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d    = S_WAIT;
          imem_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          inst_valid_d = 1'b0;
          if (target[1]) begin
            misaligned_d = 1'b1;
            state_d      = S_TRAP;
          end else begin
            pc_d       = target;
            imem_req_d = 1'b1;
            state_d    = S_REQ;
          end
        end
      end
      S_TRAP: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_valid_q ? inst_q : NOP_INST;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a bench-side memory responder pushes each returned
// word onto a scoreboard that is popped when the stage presents a valid instruction.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSel;
  logic [31:0] alu_out;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  inst_fetch #(
    .DWIDTH   (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSel       (PCSel),
    .alu_out     (alu_out),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_valid();
    exp_t e;
    chk("inst_valid", 32'(inst_valid), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    end else begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
    end
  endtask

  // Called with the stage in S_REQ; ends with the stage in S_VALID.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int unsigned gnt_dly, input int unsigned rv_dly);
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, addr);
    for (int unsigned i = 0; i < gnt_dly; i++) begin
      imem_gnt = 1'b0;
      step();
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("req_after_gnt", 32'(imem_req), 32'd0);
    chk("wait_nop", inst, NOP);
    for (int unsigned i = 0; i < rv_dly; i++) begin
      step();
      chk("wait_valid", 32'(inst_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    sb.push_back('{addr, data});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    check_valid();
  endtask

  initial begin
    rst_n       = 1'b0;
    PCSel       = 1'b0;
    alu_out     = '0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    repeat (2) step();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);

    // Boot: idle cycle, then request at address 0
    rst_n = 1'b1;
    chk("idle_req", 32'(imem_req), 32'd0);
    step();
    fetch(32'h0, 32'h0050_0113, 0, 0);

    // Sequential fetch
    step();
    chk("between_valid", 32'(inst_valid), 32'd0);
    chk("between_nop", inst, NOP);
    fetch(32'h4, 32'h00C0_0193, 0, 0);
    step();
    fetch(32'h8, 32'hFF71_8393, 0, 1);
    step();
    fetch(32'hC, 32'h0020_8233, 0, 0);

    // Stall holds everything; branch inputs are ignored while stalled
    stall   = 1'b1;
    PCSel   = 1'b1;
    alu_out = 32'h80;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0020_8233);
      chk("stall_pc", pc, 32'hC);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    PCSel = 1'b0;
    step();
    fetch(32'h10, 32'h0272_8863, 3, 0);

    // Branch taken with bit 0 set in the target
    PCSel   = 1'b1;
    alu_out = 32'h41;
    step();
    PCSel   = 1'b0;
    alu_out = '0;
    chk("pc_branch", pc, 32'h40);
    stall = 1'b1;
    fetch(32'h40, 32'h0010_0093, 0, 0);
    step();
    chk("stall_late_valid", 32'(inst_valid), 32'd1);
    chk("stall_late_pc", pc, 32'h40);
    stall = 1'b0;

    // PC wrap at top of address space
    PCSel   = 1'b1;
    alu_out = 32'hFFFF_FFFC;
    step();
    PCSel = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0000_0113, 0, 0);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    fetch(32'h0, 32'h0050_0113, 0, 0);

    // Misaligned target traps until reset
    PCSel   = 1'b1;
    alu_out = 32'h22;
    step();
    PCSel   = 1'b0;
    alu_out = '0;
    chk("trap_mis", 32'(misaligned), 32'd1);
    chk("trap_valid", 32'(inst_valid), 32'd0);
    chk("trap_inst", inst, NOP);
    chk("trap_pc", pc, 32'h0);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid_hold", 32'(inst_valid), 32'd0);
      chk("trap_mis_hold", 32'(misaligned), 32'd1);
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("trap_rst_mis", 32'(misaligned), 32'd0);
    chk("trap_rst_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    fetch(32'h0, 32'h0050_0113, 0, 0);

    // Reset asserted while waiting for the response at address 4
    step();
    chk("mid_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("mid_wait_pc", pc, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    step();
    chk("stray_idle_valid", 32'(inst_valid), 32'd0);
    chk("stray_req", 32'(imem_req), 32'd1);
    chk("stray_addr", imem_addr, 32'h0);
    // rvalid coincident with gnt must not be captured
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    chk("gnt_rvalid_same", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b0;
    step();
    chk("gnt_rvalid_wait", 32'(inst_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00C0_0193;
    sb.push_back('{32'h0, 32'h00C0_0193});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    check_valid();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage of the RV32I core. It sits directly upstream of the control decoder. It owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid handshake. It presents the fetched instruction, together with its PC, to control and the datapath. It consumes PCSel from control and the ALU result as the branch/jump target.

Parameters:
DWIDTH, 32, width of PC, addresses and target input
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, instruction driven on inst while no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
PCSel  input  1  from control; 1 = next PC is alu_out, 0 = pc+4
alu_out  input  DWIDTH  branch/jump target from ALU
stall  input  1  downstream hold; keeps current instruction presented
imem_req  output  1  fetch request
imem_addr  output  DWIDTH  fetch word address (byte address, [1:0]=0)
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
inst  output  32  instruction to control; NOP_INST when inst_valid=0
inst_valid  output  1  inst holds a fetched instruction
pc  output  DWIDTH  address of inst
pc_plus4  output  DWIDTH  pc+4, combinational, wraps modulo 2^DWIDTH
misaligned  output  1  sticky: target not 4-byte aligned

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, inst register=NOP_INST, inst_valid=0, imem_req=0, misaligned=0, state=S_IDLE.
  - Takes effect immediately, mid-transaction included.
  - Instruction memory shares rst_n and drops any outstanding response.
- States: S_IDLE, S_REQ, S_WAIT, S_VALID, S_TRAP.
- S_IDLE: first cycle after rst_n deasserts; outputs at reset values; -> S_REQ.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> S_WAIT; else stay, with addr held stable.
- S_WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> register inst=imem_rdata, inst_valid=1 -> S_VALID.
  - rvalid in the same cycle as gnt is not accepted; the response is earliest one cycle after gnt.
- S_VALID:
  - stall=1: hold pc, inst and inst_valid unchanged.
  - stall=0, next edge:
    - target = PCSel ? {alu_out[DWIDTH-1:1],1'b0} : pc_plus4.
    - If target[1]=1: misaligned<=1, inst_valid<=0 -> S_TRAP.
    - Otherwise: pc<=target, inst_valid<=0 -> S_REQ.
  - PCSel and alu_out are sampled only here, in the cycle stall=0.
- S_TRAP:
  - imem_req=0, inst_valid=0, pc frozen. Exit only via reset.
- Ignored inputs:
  - imem_rvalid outside S_WAIT.
  - imem_gnt outside S_REQ.
  - stall outside S_VALID (fetch proceeds, then holds in S_VALID).
- inst output = inst_valid ? inst register : NOP_INST. Control therefore never sees stale instructions.
- Latency: with gnt in the first S_REQ cycle and rvalid in the first S_WAIT cycle, inst_valid rises 2 cycles after entering S_REQ. Throughput is one instruction per 3 cycles minimum.
- PC arithmetic: unsigned, wraps. 32'hFFFF_FFFC + 4 = 0, with no flag.

Test Plan:
- Reset then boot: release rst_n, memory returns 32'h00500113 at addr 0 (gnt immediate, rvalid next cycle) -> imem_req high at cycle 2 with addr 0; inst_valid=1, inst=32'h00500113, pc=0, pc_plus4=4.
- Sequential fetch: PCSel=0, stall=0, memory returns 32'h00C00193, 32'hFF718393 -> next addresses 4 and 8; each inst presented for one cycle; inst=NOP_INST between.
- Branch taken: at pc=0x10 with inst 32'h02728863, PCSel=1, alu_out=0x40 -> next imem_addr=0x40, pc=0x40. With alu_out=0x41 -> bit0 cleared, fetch 0x40.
- Stall and backpressure: stall=1 for 4 cycles in S_VALID, then imem_gnt low for 3 cycles in S_REQ -> inst and pc unchanged during stall; imem_addr stable and imem_req high until gnt.
- Misaligned target: PCSel=1, alu_out=0x22 -> misaligned=1, inst_valid=0, no further imem_req until reset; a reset then restores pc=0 and misaligned=0.
- Reset mid-fetch: assert rst_n=0 in S_WAIT -> same-cycle return to reset values; a stray rvalid arriving later is not captured.
